// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Bundle of every signal exchanged between the multi-cycle controller and
//   the MIPS datapath.
//   master : the controller. It samples opcode/zero/mem_ready and drives the
//            mux selects, strobes, AluOP, the sticky illegal flag and the
//            debug state.
//   slave  : the datapath side (or a testbench standing in for it).
//   Signals
//     opcode[5:0]   IR[31:26], valid from the cycle after IRWrite
//     zero          ALU condition flag
//     mem_ready     memory completes its access this cycle
//     PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], AluOP[3:0],
//     PCSource[1:0] datapath controls
//     illegal       sticky illegal-opcode flag
//     state         current FSM state (debug)
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [3:0]         AluOP;
  logic [1:0]         PCSource;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOP, PCSource,
           illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, AluOP, PCSource,
           illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle sequencer for a MIPS datapath. One ALU and one unified
//   instruction/data memory are time-shared across fetch, decode, execute,
//   memory and writeback steps. The FSM waits on mem_ready in every memory
//   state and parks in ILLEGAL (sticky flag) on an unknown opcode until reset.
//   Ports
//     clk  system clock, rising edge
//     rst  synchronous active-high reset
//     bus  multicycle_control_if.master (datapath inputs and controls)
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter int                 STATE_W     = 4,
  parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 0,
    S_DECODE   = 1,
    S_MEMADDR  = 2,
    S_MEMREAD  = 3,
    S_MEMWB    = 4,
    S_MEMWRITE = 5,
    S_EXEC     = 6,
    S_ALUWB    = 7,
    S_BRANCH   = 8,
    S_JUMP     = 9,
    S_ILLEGAL  = 10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= state_e'(RESET_STATE);
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default up front so no
    // path through the case leaves one unassigned (no inferred latches).
    state_d         = state_q;
    op_d            = op_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.AluOP       = 4'b0000;
    bus.PCSource    = 2'b00;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed by the ALU while the instruction is read; both
        // IR and PC load only on the cycle memory actually delivers.
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        bus.ALUSrcB = 2'b11;
        op_d        = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW:                         state_d = S_MEMADDR;
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
          OP_XORI, OP_LUI, OP_SLTI:             state_d = S_EXEC;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:     state_d = S_BRANCH;
          OP_J:                                 state_d = S_JUMP;
          default:                              state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        state_d     = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWRITE: begin
        // The write strobe is held for the whole wait so the memory sees a
        // stable request until it accepts it.
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (op_q)
          OP_RTYPE: begin
            bus.ALUSrcB = 2'b00;
            bus.AluOP   = 4'b1000;
          end
          OP_ANDI: bus.AluOP = 4'b0001;
          OP_ORI:  bus.AluOP = 4'b0010;
          OP_XORI: bus.AluOP = 4'b0011;
          OP_LUI:  bus.AluOP = 4'b1010;
          OP_SLTI: bus.AluOP = 4'b1011;
          default: bus.AluOP = 4'b0000;
        endcase
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = (op_q == OP_RTYPE);
        state_d      = S_FETCH;
      end

      S_BRANCH: begin
        // The ALU decoder folds each comparison into zero, so blez/bgtz are
        // taken on zero=1 just like beq; only bne inverts it.
        bus.ALUSrcA  = 1'b1;
        bus.PCSource = 2'b01;
        case (op_q)
          OP_BEQ: begin
            bus.AluOP       = 4'b0100;
            bus.PCWriteCond = bus.zero;
          end
          OP_BNE: begin
            bus.AluOP       = 4'b0110;
            bus.PCWriteCond = ~bus.zero;
          end
          OP_BLEZ: begin
            bus.AluOP       = 4'b0111;
            bus.PCWriteCond = bus.zero;
          end
          OP_BGTZ: begin
            bus.AluOP       = 4'b1001;
            bus.PCWriteCond = bus.zero;
          end
          default: bus.PCWriteCond = 1'b0;
        endcase
        state_d = S_FETCH;
      end

      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        state_d      = S_FETCH;
      end

      S_ILLEGAL: state_d = S_ILLEGAL;

      default: state_d = S_FETCH;
    endcase

    // Reset aborts the instruction: nothing may strobe in the reset cycle.
    if (rst) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.AluOP       = 4'b0000;
      bus.PCSource    = 2'b00;
    end
  end

  // Set on the edge that enters ILLEGAL so the flag is visible together
  // with state 10; only reset clears it.
  assign illegal_d   = illegal_q | (state_d == S_ILLEGAL);
  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Table-driven bench: each record is one clock cycle of inputs plus the
//   control word expected during that cycle. Expected words go into a
//   scoreboard queue as the inputs are driven and are popped and compared
//   when the outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic [1:0] pcsrc;
  } ctl_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] opc;
    logic       zero;
    logic       rdy;
    ctl_t       exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  vec_t  vecs[$];
  ctl_t  exp_q[$];
  string name_q[$];

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- expected control words, one helper per state ----
  function automatic ctl_t e_base(input logic [3:0] st, input logic ill);
    ctl_t c;
    c     = '0;
    c.st  = st;
    c.ill = ill;
    return c;
  endfunction

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t c = e_base(4'd0, 1'b0);
    c.mrd = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy;
    return c;
  endfunction

  function automatic ctl_t e_decode();
    ctl_t c = e_base(4'd1, 1'b0);
    c.srcb = 2'b11;
    return c;
  endfunction

  function automatic ctl_t e_memaddr();
    ctl_t c = e_base(4'd2, 1'b0);
    c.srca = 1'b1; c.srcb = 2'b10;
    return c;
  endfunction

  function automatic ctl_t e_memread();
    ctl_t c = e_base(4'd3, 1'b0);
    c.mrd = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_memwb();
    ctl_t c = e_base(4'd4, 1'b0);
    c.rw = 1'b1; c.m2r = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_memwrite();
    ctl_t c = e_base(4'd5, 1'b0);
    c.mwr = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t e_exec(input logic [1:0] srcb, input logic [3:0] aluop);
    ctl_t c = e_base(4'd6, 1'b0);
    c.srca = 1'b1; c.srcb = srcb; c.aluop = aluop;
    return c;
  endfunction

  function automatic ctl_t e_aluwb(input logic rdst);
    ctl_t c = e_base(4'd7, 1'b0);
    c.rw = 1'b1; c.rdst = rdst;
    return c;
  endfunction

  function automatic ctl_t e_branch(input logic [3:0] aluop, input logic taken);
    ctl_t c = e_base(4'd8, 1'b0);
    c.srca = 1'b1; c.pcsrc = 2'b01; c.aluop = aluop; c.pcwc = taken;
    return c;
  endfunction

  function automatic ctl_t e_jump();
    ctl_t c = e_base(4'd9, 1'b0);
    c.pcw = 1'b1; c.pcsrc = 2'b10;
    return c;
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] op,
                     input logic z, input logic rdy, input ctl_t e);
    vec_t v;
    v.name = nm; v.rst = r; v.opc = op; v.zero = z; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.st    = bus.state;
    c.ill   = bus.illegal;
    c.pcw   = bus.PCWrite;
    c.pcwc  = bus.PCWriteCond;
    c.iord  = bus.IorD;
    c.mrd   = bus.MemRead;
    c.mwr   = bus.MemWrite;
    c.irw   = bus.IRWrite;
    c.m2r   = bus.MemtoReg;
    c.rdst  = bus.RegDst;
    c.rw    = bus.RegWrite;
    c.srca  = bus.ALUSrcA;
    c.srcb  = bus.ALUSrcB;
    c.aluop = bus.AluOP;
    c.pcsrc = bus.PCSource;
    return c;
  endfunction

  task automatic check(input string nm, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d word=%h, expected state=%0d word=%h",
               nm, got.st, got, exp.st, exp);
    end
  endtask

  initial begin
    ctl_t got;
    ctl_t exp;
    string nm;

    // reset sequence and lw with a stalled MEMREAD; opcode is scrambled
    // after DECODE to show only the latched copy matters
    add("rst_hold",      1, 6'h00, 0, 1, e_base(4'd0, 1'b0));
    add("lw_fetch",      0, 6'h23, 0, 1, e_fetch(1));
    add("lw_decode",     0, 6'h23, 0, 1, e_decode());
    add("lw_memaddr",    0, 6'h00, 0, 1, e_memaddr());
    add("lw_memrd_w0",   0, 6'h2b, 0, 0, e_memread());
    add("lw_memrd_w1",   0, 6'h2b, 0, 0, e_memread());
    add("lw_memrd",      0, 6'h2b, 0, 1, e_memread());
    add("lw_memwb",      0, 6'h00, 0, 1, e_memwb());
    // sw with three wait cycles in MEMWRITE
    add("sw_fetch",      0, 6'h2b, 0, 1, e_fetch(1));
    add("sw_decode",     0, 6'h2b, 0, 1, e_decode());
    add("sw_memaddr",    0, 6'h2b, 0, 1, e_memaddr());
    add("sw_memwr_w0",   0, 6'h2b, 0, 0, e_memwrite());
    add("sw_memwr_w1",   0, 6'h2b, 0, 0, e_memwrite());
    add("sw_memwr_w2",   0, 6'h2b, 0, 0, e_memwrite());
    add("sw_memwr",      0, 6'h2b, 0, 1, e_memwrite());
    // R-type with a fetch stall
    add("r_fetch_wait",  0, 6'h00, 0, 0, e_fetch(0));
    add("r_fetch",       0, 6'h00, 0, 1, e_fetch(1));
    add("r_decode",      0, 6'h00, 0, 1, e_decode());
    add("r_exec",        0, 6'h00, 0, 1, e_exec(2'b00, 4'b1000));
    add("r_aluwb",       0, 6'h00, 0, 1, e_aluwb(1));
    // I-type ALU ops
    add("ori_fetch",     0, 6'h0d, 0, 1, e_fetch(1));
    add("ori_decode",    0, 6'h0d, 0, 1, e_decode());
    add("ori_exec",      0, 6'h0d, 0, 1, e_exec(2'b10, 4'b0010));
    add("ori_aluwb",     0, 6'h0d, 0, 1, e_aluwb(0));
    add("lui_fetch",     0, 6'h0f, 0, 1, e_fetch(1));
    add("lui_decode",    0, 6'h0f, 0, 1, e_decode());
    add("lui_exec",      0, 6'h0f, 0, 1, e_exec(2'b10, 4'b1010));
    add("lui_aluwb",     0, 6'h0f, 0, 1, e_aluwb(0));
    add("slti_fetch",    0, 6'h0a, 0, 1, e_fetch(1));
    add("slti_decode",   0, 6'h0a, 0, 1, e_decode());
    add("slti_exec",     0, 6'h0a, 0, 1, e_exec(2'b10, 4'b1011));
    add("slti_aluwb",    0, 6'h0a, 0, 1, e_aluwb(0));
    add("andi_fetch",    0, 6'h0c, 0, 1, e_fetch(1));
    add("andi_decode",   0, 6'h0c, 0, 1, e_decode());
    add("andi_exec",     0, 6'h0c, 0, 1, e_exec(2'b10, 4'b0001));
    add("andi_aluwb",    0, 6'h0c, 0, 1, e_aluwb(0));
    // branches
    add("beq_fetch",     0, 6'h04, 1, 1, e_fetch(1));
    add("beq_decode",    0, 6'h04, 1, 1, e_decode());
    add("beq_taken",     0, 6'h04, 1, 1, e_branch(4'b0100, 1));
    add("bne_fetch",     0, 6'h05, 1, 1, e_fetch(1));
    add("bne_decode",    0, 6'h05, 1, 1, e_decode());
    add("bne_not_taken", 0, 6'h05, 1, 1, e_branch(4'b0110, 0));
    add("bne2_fetch",    0, 6'h05, 0, 1, e_fetch(1));
    add("bne2_decode",   0, 6'h05, 0, 1, e_decode());
    add("bne_taken",     0, 6'h05, 0, 1, e_branch(4'b0110, 1));
    add("blez_fetch",    0, 6'h06, 0, 1, e_fetch(1));
    add("blez_decode",   0, 6'h06, 0, 1, e_decode());
    add("blez_not_tkn",  0, 6'h06, 0, 1, e_branch(4'b0111, 0));
    add("bgtz_fetch",    0, 6'h07, 1, 1, e_fetch(1));
    add("bgtz_decode",   0, 6'h07, 1, 1, e_decode());
    add("bgtz_taken",    0, 6'h07, 1, 1, e_branch(4'b1001, 1));
    // jump
    add("j_fetch",       0, 6'h02, 0, 1, e_fetch(1));
    add("j_decode",      0, 6'h02, 0, 1, e_decode());
    add("j_jump",        0, 6'h02, 0, 1, e_jump());
    // reset in the middle of an instruction: outputs dead, state still shown
    add("abort_fetch",   0, 6'h23, 0, 1, e_fetch(1));
    add("abort_decode",  1, 6'h23, 0, 1, e_base(4'd1, 1'b0));
    // illegal opcode parks with the sticky flag until reset
    add("ill_fetch",     0, 6'h3f, 0, 1, e_fetch(1));
    add("ill_decode",    0, 6'h3f, 0, 1, e_decode());
    for (int i = 0; i < 10; i++)
      add($sformatf("ill_hold%0d", i), 0, 6'(i * 7), i[0], i[1], e_base(4'd10, 1'b1));
    add("ill_rst",       1, 6'h00, 0, 1, e_base(4'd10, 1'b1));
    add("post_ill_rst",  1, 6'h00, 0, 1, e_base(4'd0, 1'b0));
    add("post_rst_fetch",0, 6'h00, 0, 1, e_fetch(1));

    // one unchecked reset cycle so the state register is defined
    rst           = 1'b1;
    bus.opcode    = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      bus.opcode    = vecs[i].opc;
      bus.zero      = vecs[i].zero;
      bus.mem_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      #2;
      got = sample();
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue, expected entry %0d", i);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        check(nm, got, exp);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
